// File: rtl/segre_pkg.sv
// Shared types for the Segre core decode path: opcodes, ALU ops, mux selects,
// memop encodings, the registered decode bundle and register-usage helpers.
package segre_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_JAL, ALU_JALR, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV,
    ALU_DIVU, ALU_REM, ALU_REMU
  } alu_opcode_e;

  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_sel_e;
  typedef enum logic       {SRC_B_RS2, SRC_B_IMM}            src_b_sel_e;
  typedef enum logic [1:0] {MEMOP_BYTE, MEMOP_HALF, MEMOP_WORD} memop_type_e;

  typedef struct packed {
    alu_opcode_e       alu_opcode;
    src_a_sel_e        src_a_sel;
    src_b_sel_e        src_b_sel;
    logic [REG_AW-1:0] raddr_a;
    logic [REG_AW-1:0] raddr_b;
    logic [REG_AW-1:0] waddr;
    logic              rf_we;
    memop_type_e       memop_type;
    logic              memop_sign;
    logic              memop_rd;
    logic              memop_wr;
    logic [XLEN-1:0]   imm;
  } decode_bundle_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/segre_instr_decoder.sv
// Combinational RV32I decoder; M-extension encodings decode only when
// SEGRE_RV32M_EN is defined, otherwise they are flagged illegal.
module segre_instr_decoder
  import segre_pkg::*;
(
  input  logic [XLEN-1:0]                   instr_i,
  output logic [$bits(decode_bundle_t)-1:0] dec_o,
  output logic                              illegal_o,
  output logic                              uses_rs1_o,
  output logic                              uses_rs2_o
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  decode_bundle_t  d;
  logic            illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    d            = '0;
    d.alu_opcode = ALU_ADD;
    d.src_a_sel  = SRC_A_RS1;
    d.src_b_sel  = SRC_B_IMM;
    d.raddr_a    = instr_i[19:15];
    d.raddr_b    = instr_i[24:20];
    d.waddr      = instr_i[11:7];
    illegal      = 1'b0;
    case (opcode)
      OPC_LUI:   begin d.rf_we = 1'b1; d.src_a_sel = SRC_A_ZERO; d.imm = imm_u; end
      OPC_AUIPC: begin d.rf_we = 1'b1; d.src_a_sel = SRC_A_PC;   d.imm = imm_u; end
      OPC_JAL:   begin d.rf_we = 1'b1; d.alu_opcode = ALU_JAL; d.src_a_sel = SRC_A_PC; d.imm = imm_j; end
      OPC_JALR:  begin
        d.rf_we = 1'b1; d.alu_opcode = ALU_JALR; d.imm = imm_i;
        illegal = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        d.imm = imm_b; d.src_b_sel = SRC_B_RS2;
        case (funct3)
          3'd0: d.alu_opcode = ALU_BEQ;
          3'd1: d.alu_opcode = ALU_BNE;
          3'd4: d.alu_opcode = ALU_BLT;
          3'd5: d.alu_opcode = ALU_BGE;
          3'd6: d.alu_opcode = ALU_BLTU;
          3'd7: d.alu_opcode = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.rf_we = 1'b1; d.memop_rd = 1'b1; d.imm = imm_i;
        d.memop_sign = !funct3[2];
        case (funct3)
          3'd0, 3'd4: d.memop_type = MEMOP_BYTE;
          3'd1, 3'd5: d.memop_type = MEMOP_HALF;
          3'd2:       d.memop_type = MEMOP_WORD;
          default:    illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d.memop_wr = 1'b1; d.imm = imm_s;
        case (funct3)
          3'd0:    d.memop_type = MEMOP_BYTE;
          3'd1:    d.memop_type = MEMOP_HALF;
          3'd2:    d.memop_type = MEMOP_WORD;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        d.rf_we = 1'b1; d.imm = imm_i;
        case (funct3)
          3'd0: d.alu_opcode = ALU_ADD;
          3'd1: begin d.alu_opcode = ALU_SLL; illegal = (funct7 != 7'b0000000); end
          3'd2: d.alu_opcode = ALU_SLT;
          3'd3: d.alu_opcode = ALU_SLTU;
          3'd4: d.alu_opcode = ALU_XOR;
          3'd5: begin
            d.alu_opcode = funct7[5] ? ALU_SRA : ALU_SRL;
            illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
          3'd6: d.alu_opcode = ALU_OR;
          default: d.alu_opcode = ALU_AND;
        endcase
      end
      OPC_OP: begin
        d.rf_we = 1'b1; d.src_b_sel = SRC_B_RS2;
        case (funct7)
          7'b0000000:
            case (funct3)
              3'd0: d.alu_opcode = ALU_ADD;
              3'd1: d.alu_opcode = ALU_SLL;
              3'd2: d.alu_opcode = ALU_SLT;
              3'd3: d.alu_opcode = ALU_SLTU;
              3'd4: d.alu_opcode = ALU_XOR;
              3'd5: d.alu_opcode = ALU_SRL;
              3'd6: d.alu_opcode = ALU_OR;
              default: d.alu_opcode = ALU_AND;
            endcase
          7'b0100000:
            case (funct3)
              3'd0: d.alu_opcode = ALU_SUB;
              3'd5: d.alu_opcode = ALU_SRA;
              default: illegal = 1'b1;
            endcase
`ifdef SEGRE_RV32M_EN
          7'b0000001:
            case (funct3)
              3'd0: d.alu_opcode = ALU_MUL;
              3'd1: d.alu_opcode = ALU_MULH;
              3'd2: d.alu_opcode = ALU_MULHSU;
              3'd3: d.alu_opcode = ALU_MULHU;
              3'd4: d.alu_opcode = ALU_DIV;
              3'd5: d.alu_opcode = ALU_DIVU;
              3'd6: d.alu_opcode = ALU_REM;
              default: d.alu_opcode = ALU_REMU;
            endcase
`endif
          default: illegal = 1'b1;
        endcase
      end
      OPC_FENCE: ;
      default: illegal = 1'b1;
    endcase
    // Illegal instructions travel down the pipe but must have no side effects.
    if (illegal) begin
      d.rf_we    = 1'b0;
      d.memop_rd = 1'b0;
      d.memop_wr = 1'b0;
    end
  end

  assign dec_o      = d;
  assign illegal_o  = illegal;
  assign uses_rs1_o = uses_rs1(opcode);
  assign uses_rs2_o = uses_rs2(opcode);

endmodule

// File: rtl/segre_decode_stage.sv
// Buffered decode stage: instruction FIFO, head decode, write-pending scoreboard
// and registered decode output. SEGRE_RV32M_EN enables M-extension decode.
module segre_decode_stage
  import segre_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned REG_SIZE   = 5,
  parameter int unsigned IBUF_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rsn_i,
  input  logic                              fetch_valid_i,
  input  logic [WORD_SIZE-1:0]              fetch_instr_i,
  input  logic [WORD_SIZE-1:0]              fetch_pc_i,
  output logic                              fetch_ready_o,
  input  logic                              flush_i,
  input  logic                              wb_valid_i,
  input  logic [REG_SIZE-1:0]               wb_addr_i,
  input  logic                              ex_ready_i,
  output logic                              dec_valid_o,
  output logic [$bits(decode_bundle_t)-1:0] dec_o,
  output logic [WORD_SIZE-1:0]              dec_pc_o,
  output logic                              dec_illegal_o,
  output logic                              stall_o
);

  localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
  localparam int unsigned NREG  = 2 ** REG_SIZE;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
  } ibuf_entry_t;

  ibuf_entry_t [IBUF_DEPTH-1:0] ibuf_q, ibuf_d;
  logic [PTR_W:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NREG-1:0]              busy_q, busy_d, busy_eff, wb_clr;
  logic                         dec_valid_q, dec_valid_d, dec_illegal_q, dec_illegal_d;
  decode_bundle_t               dec_q, dec_d, head_dec;
  logic [WORD_SIZE-1:0]         dec_pc_q, dec_pc_d;

  ibuf_entry_t head;
  logic        full, head_valid, head_illegal, head_rs1, head_rs2;
  logic        hazard, issue, push;

  assign full = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign head_valid = (wr_ptr_q != rd_ptr_q);
  assign head       = ibuf_q[rd_ptr_q[PTR_W-1:0]];

  segre_instr_decoder u_decoder (
    .instr_i    (head.instr),
    .dec_o      (head_dec),
    .illegal_o  (head_illegal),
    .uses_rs1_o (head_rs1),
    .uses_rs2_o (head_rs2)
  );

  // A writeback landing this cycle already resolves the hazard on its register.
  assign wb_clr   = wb_valid_i ? (NREG'(1) << wb_addr_i) : '0;
  assign busy_eff = busy_q & ~wb_clr;

  assign hazard = !head_illegal &&
                  ((head_rs1 && busy_eff[head_dec.raddr_a]) ||
                   (head_rs2 && busy_eff[head_dec.raddr_b]) ||
                   (head_dec.rf_we && busy_eff[head_dec.waddr]));

  assign issue = head_valid && !hazard && (!dec_valid_q || ex_ready_i) && !flush_i;
  assign push  = fetch_valid_i && !full && !flush_i;

  always_comb begin
    ibuf_d        = ibuf_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    busy_d        = busy_eff;
    dec_valid_d   = dec_valid_q;
    dec_d         = dec_q;
    dec_pc_d      = dec_pc_q;
    dec_illegal_d = dec_illegal_q;
    if (push) begin
      ibuf_d[wr_ptr_q[PTR_W-1:0]] = '{instr: fetch_instr_i, pc: fetch_pc_i};
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (issue) begin
      rd_ptr_d      = rd_ptr_q + (PTR_W+1)'(1);
      dec_valid_d   = 1'b1;
      dec_d         = head_dec;
      dec_pc_d      = head.pc;
      dec_illegal_d = head_illegal;
      if (head_dec.rf_we) busy_d[head_dec.waddr] = 1'b1;
    end else if (ex_ready_i) begin
      dec_valid_d = 1'b0;
    end
    // Flush drops queued work only; in-flight writes still retire, so busy stays.
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      dec_valid_d = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      ibuf_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      busy_q        <= '0;
      dec_valid_q   <= 1'b0;
      dec_q         <= '0;
      dec_pc_q      <= '0;
      dec_illegal_q <= 1'b0;
    end else begin
      ibuf_q        <= ibuf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      busy_q        <= busy_d;
      dec_valid_q   <= dec_valid_d;
      dec_q         <= dec_d;
      dec_pc_q      <= dec_pc_d;
      dec_illegal_q <= dec_illegal_d;
    end
  end

  assign fetch_ready_o = !full;
  assign dec_valid_o   = dec_valid_q;
  assign dec_o         = dec_q;
  assign dec_pc_o      = dec_pc_q;
  assign dec_illegal_o = dec_illegal_q;
  assign stall_o       = head_valid && hazard;

endmodule

// File: tb/tb_segre_decode_stage.sv
// Directed bench for segre_decode_stage with an in-order expectation queue.
`timescale 1ns/1ps
module tb_segre_decode_stage;
  import segre_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rsn_i, fetch_valid_i, flush_i, wb_valid_i, ex_ready_i;
  logic [31:0] fetch_instr_i, fetch_pc_i;
  logic [4:0]  wb_addr_i;
  logic        fetch_ready_o, dec_valid_o, dec_illegal_o, stall_o;
  logic [$bits(decode_bundle_t)-1:0] dec_o;
  logic [31:0] dec_pc_o;
  decode_bundle_t d;

  assign d = dec_o;
  always #5 clk = ~clk;

  segre_decode_stage #(.WORD_SIZE(32), .REG_SIZE(5), .IBUF_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rsn_i(rsn_i), .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i),
    .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o), .flush_i(flush_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .ex_ready_i(ex_ready_i),
    .dec_valid_o(dec_valid_o), .dec_o(dec_o), .dec_pc_o(dec_pc_o),
    .dec_illegal_o(dec_illegal_o), .stall_o(stall_o)
  );

  // mask: bit0 check alu, bit1 check imm, bit2 check waddr
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic        rf_we;
    logic        illegal;
    logic [2:0]  mask;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  int unsigned total = 0, bad = 0, npush = 0, npop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_set(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] alu,
                          input logic [31:0] imm, input logic [4:0] waddr, input logic rf_we,
                          input logic illegal, input logic [2:0] mask);
    fetch_valid_i = 1'b1;
    fetch_instr_i = instr;
    fetch_pc_i    = pc;
    pend = '{pc: pc, alu: alu, imm: imm, waddr: waddr, rf_we: rf_we, illegal: illegal, mask: mask};
  endtask

  // One clock: compare any handshake at the negedge, record accepted pushes, then step.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (dec_valid_o && ex_ready_i) begin
      npop++;
      chk("expect_available", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc", dec_pc_o, e.pc);
        chk("illegal", 32'(dec_illegal_o), 32'(e.illegal));
        chk("rf_we", 32'(d.rf_we), 32'(e.rf_we));
        if (e.illegal) chk("illegal_memop", {30'b0, d.memop_rd, d.memop_wr}, 32'd0);
        if (e.mask[0]) chk("alu", 32'(d.alu_opcode), 32'(e.alu));
        if (e.mask[1]) chk("imm", d.imm, e.imm);
        if (e.mask[2]) chk("waddr", 32'(d.waddr), 32'(e.waddr));
      end
    end
    if (flush_i) q.delete();
    if (fetch_valid_i && fetch_ready_o && !flush_i) begin
      q.push_back(pend);
      npush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) cyc();
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  int unsigned p0;

  initial begin
    rsn_i = 1'b0; fetch_valid_i = 1'b0; fetch_instr_i = '0; fetch_pc_i = '0;
    flush_i = 1'b0; wb_valid_i = 1'b0; wb_addr_i = '0; ex_ready_i = 1'b1;
    pend = '{pc: 0, alu: 0, imm: 0, waddr: 0, rf_we: 0, illegal: 0, mask: 0};
    repeat (2) @(negedge clk);
    chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("rst_dec_zero", 32'(dec_o === '0), 32'd1);
    chk("rst_dec_pc", dec_pc_o, 32'd0);
    chk("rst_illegal", 32'(dec_illegal_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1 rsn_i = 1'b1;

    // addi x1,x0,5: two-cycle latency
    push_set(32'h00500093, 32'h100, ALU_ADD, 32'd5, 5'd1, 1'b1, 1'b0, 3'b111);
    cyc(); fetch_valid_i = 1'b0;
    chk("lat_n1_not_valid", 32'(dec_valid_o), 32'd0);
    cyc();
    chk("lat_n2_valid", 32'(dec_valid_o), 32'd1);
    cyc();

    // add x2,x1,x1 waits on x1, issues in the writeback cycle
    push_set(32'h00108133, 32'h104, ALU_ADD, 32'd0, 5'd2, 1'b1, 1'b0, 3'b101);
    cyc(); fetch_valid_i = 1'b0;
    chk("raw_stall_a", 32'(stall_o), 32'd1);
    cyc();
    chk("raw_stall_b", 32'(stall_o), 32'd1);
    chk("raw_no_issue", 32'(dec_valid_o), 32'd0);
    wb_valid_i = 1'b1; wb_addr_i = 5'd1;
    #1 chk("wb_clears_stall", 32'(stall_o), 32'd0);
    cyc();
    chk("issue_on_wb", 32'(dec_valid_o), 32'd1);
    wb_addr_i = 5'd2;
    cyc(); wb_valid_i = 1'b0;

    // mul x3,x1,x2
`ifdef SEGRE_RV32M_EN
    push_set(32'h022081B3, 32'h108, ALU_MUL, 32'd0, 5'd3, 1'b1, 1'b0, 3'b101);
`else
    push_set(32'h022081B3, 32'h108, ALU_ADD, 32'd0, 5'd0, 1'b0, 1'b1, 3'b000);
`endif
    cyc(); fetch_valid_i = 1'b0;
    cyc();
    chk("mul_no_stall", 32'(stall_o), 32'd0);
    drain();

    // back-to-back: two illegals (second has rd=x1), then x1 reader, load, branch
    p0 = npop;
    push_set(32'h00000000, 32'h10C, ALU_ADD, 32'd0, 5'd0, 1'b0, 1'b1, 3'b000); cyc();
    push_set(32'h000000FF, 32'h110, ALU_ADD, 32'd0, 5'd0, 1'b0, 1'b1, 3'b000); cyc();
    push_set(32'h000082B3, 32'h114, ALU_ADD, 32'd0, 5'd5, 1'b1, 1'b0, 3'b101); cyc();
    push_set(32'hFFC12403, 32'h118, ALU_ADD, 32'hFFFFFFFC, 5'd8, 1'b1, 1'b0, 3'b111); cyc();
    push_set(32'h00000463, 32'h11C, ALU_BEQ, 32'd8, 5'd0, 1'b0, 1'b0, 3'b011); cyc();
    fetch_valid_i = 1'b0;
    cyc(); cyc();
    chk("throughput_pops", npop - p0, 32'd5);
    drain();

    // fill with ex_ready low: one in output reg plus DEPTH buffered
    ex_ready_i = 1'b0;
    p0 = npush;
    for (int k = 1; k <= 8; k++)
      begin
        push_set(32'h00000013 | (k << 20), 32'h200 + 4 * k, ALU_ADD, k, 5'd0, 1'b1, 1'b0, 3'b111);
        cyc();
      end
    fetch_valid_i = 1'b0;
    chk("full_accepted", npush - p0, DEPTH + 1);
    chk("full_not_ready", 32'(fetch_ready_o), 32'd0);
    chk("hold_valid", 32'(dec_valid_o), 32'd1);
    cyc(); cyc();
    chk("hold_pc", dec_pc_o, 32'h204);
    chk("hold_imm", d.imm, 32'd1);
    // release while still offering a push: no slot until the pop has landed
    push_set(32'h00900013, 32'h224, ALU_ADD, 32'd9, 5'd0, 1'b1, 1'b0, 3'b111);
    ex_ready_i = 1'b1;
    chk("full_pop_cycle_not_ready", 32'(fetch_ready_o), 32'd0);
    cyc();
    chk("ready_after_pop", 32'(fetch_ready_o), 32'd1);
    cyc(); fetch_valid_i = 1'b0;
    drain();

    // flush with three buffered; busy[6] from an issued instruction must survive
    push_set(32'h00100313, 32'h300, ALU_ADD, 32'd1, 5'd6, 1'b1, 1'b0, 3'b111); cyc();
    fetch_valid_i = 1'b0;
    drain();
    ex_ready_i = 1'b0;
    for (int k = 20; k < 24; k++) begin
      push_set(32'h00000013 | (k << 20), 32'h310 + 4 * (k - 20), ALU_ADD, k, 5'd0, 1'b1, 1'b0, 3'b111);
      cyc();
    end
    chk("preflush_valid", 32'(dec_valid_o), 32'd1);
    flush_i = 1'b1;
    push_set(32'h00F00013, 32'h330, ALU_ADD, 32'd15, 5'd0, 1'b1, 1'b0, 3'b111);
    cyc();
    flush_i = 1'b0; fetch_valid_i = 1'b0;
    chk("flush_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("flush_ready", 32'(fetch_ready_o), 32'd1);
    ex_ready_i = 1'b1;
    p0 = npop;
    cyc(); cyc(); cyc();
    chk("flush_fifo_empty", npop - p0, 32'd0);
    push_set(32'h000303B3, 32'h340, ALU_ADD, 32'd0, 5'd7, 1'b1, 1'b0, 3'b101);
    cyc(); fetch_valid_i = 1'b0;
    chk("busy_kept_stall", 32'(stall_o), 32'd1);
    cyc();
    chk("busy_kept_stall_b", 32'(stall_o), 32'd1);
    wb_valid_i = 1'b1; wb_addr_i = 5'd6;
    cyc(); wb_valid_i = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segre_decode_stage.md
# segre_decode_stage

Buffered, hazard-aware decode stage for the Segre RV32I(M) core, sitting between fetch and execute. It accepts instructions from fetch into a parametrised instruction buffer, decodes the head entry into a registered decode bundle, and blocks issue on register hazards using a write-pending scoreboard. It flags illegal encodings in-band rather than asserting.

## Interface
Parameters:
- WORD_SIZE, 32, instruction/PC/immediate width
- REG_SIZE, 5, register address width
- IBUF_DEPTH, 4, instruction buffer entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock; one clock domain
- rsn_i  in  1  reset, asynchronous, active-low
- fetch_valid_i  in  1  fetch has an instruction
- fetch_instr_i  in  WORD_SIZE  instruction word
- fetch_pc_i  in  WORD_SIZE  PC of instruction
- fetch_ready_o  out  1  buffer not full
- flush_i  in  1  discard buffered and registered instructions
- wb_valid_i  in  1  writeback retiring a register write
- wb_addr_i  in  REG_SIZE  register being written back
- ex_ready_i  in  1  execute accepts dec_o this cycle
- dec_valid_o  out  1  dec_o/dec_pc_o valid
- dec_o  out  $bits(decode_bundle_t)  decoded fields
- dec_pc_o  out  WORD_SIZE  PC of decoded instruction
- dec_illegal_o  out  1  instruction in dec_o is illegal
- stall_o  out  1  head valid but blocked by hazard

## Operation
- Buffer: circular FIFO, IBUF_DEPTH entries of {instr, pc}. Push on fetch_valid_i & fetch_ready_o; fetch_ready_o = !full. Pointers have one extra wrap bit; full = same index, different wrap bit.
- Decode: head entry decoded combinationally into decode_bundle_t (ALU opcode, mux selects, raddr_a/b, waddr, rf_we, memop type/sign/rd/wr, selected immediate).
- Source use: rs1 for OP, OP_IMM, LOAD, STORE, BRANCH, JALR; rs2 for OP, STORE, BRANCH.
- Scoreboard: busy[31:0]; busy[0] always 0. Hazard = head uses rsN and busy[rsN], or rf_we and busy[rd] (WAW).
- Effective busy = busy & ~(wb_valid_i ? onehot(wb_addr_i) : 0): same-cycle writeback clears hazard.
- Issue when head valid, no hazard, and (!dec_valid_o | ex_ready_i). Issue pops FIFO, loads output register, sets busy[rd] if rf_we & rd≠0. Same-cycle set and clear of one register: set wins.
- Illegal (unknown opcode, bad funct3/funct7): issues with dec_illegal_o=1, rf_we=0, memop rd/wr=0, no scoreboard set, no hazard check.
- stall_o = head valid & hazard.
- flush_i: empty FIFO, clear dec_valid_o next cycle; scoreboard preserved (older instructions still write back). Push in flush cycle is dropped.

## Timing
- Reset: FIFO empty, fetch_ready_o=1, dec_valid_o=0, dec_o=0, dec_pc_o=0, dec_illegal_o=0, stall_o=0, busy=0.
- Latency: pushed at edge ending cycle N → dec_valid_o in cycle N+2 if no hazard.
- Throughput: one instruction/cycle with ex_ready_i=1 and no hazards.
- dec_o held stable while dec_valid_o & !ex_ready_i.
- Push and pop in same cycle allowed when full (pop frees slot only next cycle; fetch_ready_o stays 0 that cycle).
- Reset mid-operation discards everything asynchronously.

## Configuration
- SEGRE_RV32M_EN defined: OP with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Undefined: those encodings are illegal (dec_illegal_o=1).

## Structure
- segre_pkg gains decode_bundle_t (packed struct) and rs-usage helper functions; reuses existing opcode_e, alu_opcode_e, mux-select and memop enums.
- Sub-module segre_instr_decoder: pure combinational instr → {decode_bundle_t, illegal, uses_rs1, uses_rs2}; FIFO and scoreboard live in the top.

## Test plan
- Push 0x00500093 (addi x1,x0,5), ex_ready_i=1 → dec_valid_o two cycles later, ALU_ADD, imm=5, waddr=1; busy[1]=1.
- Then 0x00108133 (add x2,x1,x1) → stall_o=1 until wb_valid_i/wb_addr_i=1; issues the same cycle writeback arrives.
- Push 0x022081B3 (mul x3,x1,x2) → ALU_MUL with SEGRE_RV32M_EN; dec_illegal_o=1 without.
- Push 0x00000000 → dec_illegal_o=1, rf_we=0, busy unchanged; next instruction issues normally.
- Fill IBUF_DEPTH entries with ex_ready_i=0 → fetch_ready_o=0; extra push ignored; release → entries issue in order, wrap correct.
- flush_i with 3 buffered → dec_valid_o=0 next cycle, FIFO empty, busy bits from issued instructions retained.
